// File: rtl/rissy_seq_ctrl_if.sv
// Bundle of the sequencer's memory-port, register-file and ALU signals.
// The master side is the sequencer; the slave side is the surrounding core.
interface rissy_seq_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  logic [15:0] rf_data_a;
  logic [15:0] rf_data_b;
  logic [15:0] alu_result;
  logic [2:0]  rf_ra_add;
  logic [2:0]  rf_rb_add;
  logic        rf_w_en;
  logic [2:0]  rf_write_add;
  logic [15:0] rf_write_data;
  logic        rf_pc_inc;
  logic [2:0]  alu_op;

  logic        halted;
  logic        fault;

  modport master (
    output imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           rf_ra_add, rf_rb_add, rf_w_en, rf_write_add, rf_write_data,
           rf_pc_inc, alu_op, halted, fault,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata,
           rf_data_a, rf_data_b, alu_result
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           rf_ra_add, rf_rb_add, rf_w_en, rf_write_add, rf_write_data,
           rf_pc_inc, alu_op, halted, fault,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata,
           rf_data_a, rf_data_b, alu_result
  );
endinterface

// File: rtl/rissy_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit Rissy core: fetch, decode, execute,
// memory access and writeback, with a bus-wait timeout into a sticky fault.
module rissy_seq_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  rissy_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BEQZ  = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Last wait cycle that may still end in an ack; no ack here means fault.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] res;
  logic [7:0]  wait_cnt;

  logic [3:0]  op;
  logic [2:0]  rd;
  logic        wait_expired;
  logic        ir_low_unused;

  assign op            = ir[15:12];
  assign rd            = ir[11:9];
  assign wait_expired  = (wait_cnt == WAIT_LAST);
  assign ir_low_unused = ^ir[2:0];

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of state/ir, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      ir       <= '0;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir       <= bus.imem_rdata;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_expired) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_DECODE: state <= S_EXEC;

        S_EXEC: begin
          opa      <= bus.rf_data_a;
          opb      <= bus.rf_data_b;
          res      <= bus.alu_result;
          wait_cnt <= '0;
          if (!op[3]) begin
            state <= S_WB;
          end else begin
            case (op)
              OP_LOAD, OP_STORE: state <= S_MEM;
              OP_BEQZ:           state <= (bus.rf_data_a == 16'h0000) ? S_WB : S_FETCH;
              OP_HALT:           state <= S_HALT;
              default:           state <= S_FETCH;
            endcase
          end
        end

        S_MEM: begin
          if (bus.dmem_ack) begin
            wait_cnt <= '0;
            if (op == OP_LOAD) begin
              res   <= bus.dmem_rdata;
              state <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end else if (wait_expired) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end

        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  // Moore outputs: pure decodes of the state register and captured operands.
  assign bus.imem_req      = (state == S_FETCH);
  assign bus.rf_pc_inc     = (state == S_DECODE);
  assign bus.dmem_req      = (state == S_MEM);
  assign bus.dmem_we       = (state == S_MEM) && (op == OP_STORE);
  assign bus.dmem_addr     = opa;
  assign bus.dmem_wdata    = opb;
  assign bus.rf_w_en       = (state == S_WB);
  assign bus.rf_write_add  = (op == OP_BEQZ) ? 3'd7 : rd;
  assign bus.rf_write_data = (op == OP_BEQZ) ? opb  : res;
  assign bus.rf_ra_add     = ir[8:6];
  assign bus.rf_rb_add     = ir[5:3];
  assign bus.alu_op        = ir[14:12];
  assign bus.halted        = (state == S_HALT);
  assign bus.fault         = (state == S_FAULT);

endmodule

// File: tb/tb_rissy_seq_ctrl.sv
// Directed bench for rissy_seq_ctrl: a small register-file model feeds the
// read ports; each step checks the sequencer's outputs against hand values.
module tb_rissy_seq_ctrl;
  logic clk = 1'b0;
  logic rst;

  rissy_seq_ctrl_if bus ();

  rissy_seq_ctrl #(.TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [8];
  assign bus.rf_data_a = regs[bus.rf_ra_add];
  assign bus.rf_data_b = regs[bus.rf_rb_add];

  int checks     = 0;
  int errors     = 0;
  int pc_inc_cnt = 0;
  int w_en_cnt   = 0;
  int pc_base;
  int w_base;
  int n;

  always @(negedge clk) begin
    if (bus.rf_pc_inc === 1'b1) pc_inc_cnt++;
    if (bus.rf_w_en === 1'b1)   w_en_cnt++;
  end

  task automatic step(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Must be called while the sequencer is in FETCH; returns in DECODE.
  task automatic fetch(input logic [15:0] instr);
    bus.imem_rdata = instr;
    bus.imem_ack   = 1'b1;
    step();
    bus.imem_ack   = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0000;
    bus.alu_result = 16'h0000;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[1] = 16'h0040;
    regs[2] = 16'h0001;
    regs[4] = 16'h0010;
    regs[5] = 16'h00AA;
    regs[6] = 16'h0100;

    // Reset state
    step(2);
    check("rst_w_en",     16'(bus.rf_w_en),   16'h0);
    check("rst_pc_inc",   16'(bus.rf_pc_inc), 16'h0);
    check("rst_dmem_req", 16'(bus.dmem_req),  16'h0);
    check("rst_halted",   16'(bus.halted),    16'h0);
    check("rst_fault",    16'(bus.fault),     16'h0);
    rst = 1'b0;
    check("first_imem_req", 16'(bus.imem_req), 16'h1);

    // ALU op 0x1, rd=3, ra=5, rb=2
    pc_base = pc_inc_cnt;
    bus.alu_result = 16'h1234;
    fetch(16'h1750);
    check("alu_pc_inc",   16'(bus.rf_pc_inc), 16'h1);
    check("alu_dec_ireq", 16'(bus.imem_req),  16'h0);
    step();
    check("alu_ra_add",   16'(bus.rf_ra_add), 16'h5);
    check("alu_rb_add",   16'(bus.rf_rb_add), 16'h2);
    check("alu_op",       16'(bus.alu_op),    16'h1);
    check("alu_exec_inc", 16'(bus.rf_pc_inc), 16'h0);
    step();
    bus.alu_result = 16'h0000;
    check("alu_w_en",  16'(bus.rf_w_en),      16'h1);
    check("alu_wadd",  16'(bus.rf_write_add), 16'h3);
    check("alu_wdata", bus.rf_write_data,     16'h1234);
    step();
    check("alu_c5_ireq",  16'(bus.imem_req),  16'h1);
    check("alu_c5_w_en",  16'(bus.rf_w_en),   16'h0);
    check("alu_inc_once", 16'(pc_inc_cnt - pc_base), 16'h1);

    // LOAD rd=2, ra=1, three wait cycles
    fetch(16'h8440);
    step();
    step();
    check("ld_dreq", 16'(bus.dmem_req), 16'h1);
    check("ld_addr", bus.dmem_addr,     16'h0040);
    check("ld_we",   16'(bus.dmem_we),  16'h0);
    step(2);
    check("ld_wait_dreq", 16'(bus.dmem_req), 16'h1);
    step();
    bus.dmem_rdata = 16'hBEEF;
    bus.dmem_ack   = 1'b1;
    step();
    bus.dmem_ack   = 1'b0;
    check("ld_w_en",  16'(bus.rf_w_en),      16'h1);
    check("ld_wadd",  16'(bus.rf_write_add), 16'h2);
    check("ld_wdata", bus.rf_write_data,     16'hBEEF);
    check("ld_wb_dreq", 16'(bus.dmem_req),   16'h0);
    step();
    check("ld_c9_ireq", 16'(bus.imem_req),   16'h1);

    // STORE ra=4, rb=5
    w_base = w_en_cnt;
    fetch(16'h9128);
    step(2);
    check("st_dreq",  16'(bus.dmem_req), 16'h1);
    check("st_we",    16'(bus.dmem_we),  16'h1);
    check("st_addr",  bus.dmem_addr,     16'h0010);
    check("st_wdata", bus.dmem_wdata,    16'h00AA);
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
    check("st_c5_ireq", 16'(bus.imem_req), 16'h1);
    check("st_c5_dreq", 16'(bus.dmem_req), 16'h0);
    check("st_no_write", 16'(w_en_cnt - w_base), 16'h0);

    // BEQZ taken: R0 == 0, target R6
    fetch(16'hCA30);
    step(2);
    check("bz_w_en",  16'(bus.rf_w_en),      16'h1);
    check("bz_wadd",  16'(bus.rf_write_add), 16'h7);
    check("bz_wdata", bus.rf_write_data,     16'h0100);
    step();
    check("bz_ireq", 16'(bus.imem_req), 16'h1);

    // BEQZ not taken: R2 == 1
    w_base = w_en_cnt;
    fetch(16'hC0B0);
    step(2);
    check("bnz_ireq",  16'(bus.imem_req), 16'h1);
    check("bnz_no_wr", 16'(w_en_cnt - w_base), 16'h0);

    // NOP
    fetch(16'hA000);
    step(2);
    check("nop_ireq", 16'(bus.imem_req), 16'h1);

    // imem_ack on the last allowed wait cycle still succeeds
    step(254);
    check("to_edge_ireq",  16'(bus.imem_req), 16'h1);
    check("to_edge_fault", 16'(bus.fault),    16'h0);
    fetch(16'hA000);
    check("to_edge_pc_inc", 16'(bus.rf_pc_inc), 16'h1);
    check("to_edge_nofault", 16'(bus.fault),    16'h0);
    step(2);

    // imem_ack never arrives
    n = 0;
    while (bus.imem_req === 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("to_req_cycles", 16'(n), 16'd255);
    check("to_fault",      16'(bus.fault),    16'h1);
    check("to_ireq",       16'(bus.imem_req), 16'h0);
    step(5);
    check("to_sticky_fault", 16'(bus.fault),    16'h1);
    check("to_sticky_ireq",  16'(bus.imem_req), 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("to_rst_fault", 16'(bus.fault),    16'h0);
    check("to_rst_ireq",  16'(bus.imem_req), 16'h1);

    // HALT
    fetch(16'hF000);
    step(2);
    check("halt_halted", 16'(bus.halted),   16'h1);
    check("halt_ireq",   16'(bus.imem_req), 16'h0);
    step(4);
    check("halt_sticky", 16'(bus.halted),   16'h1);
    check("halt_no_req", 16'(bus.imem_req | bus.dmem_req), 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("halt_rst", 16'(bus.halted), 16'h0);

    // Reset in the middle of a LOAD's MEM phase, with an ack in the reset cycle
    w_base = w_en_cnt;
    fetch(16'h8440);
    step(2);
    check("mr_dreq", 16'(bus.dmem_req), 16'h1);
    rst            = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 16'h1111;
    step();
    rst          = 1'b0;
    bus.dmem_ack = 1'b0;
    check("mr_dreq_drop", 16'(bus.dmem_req), 16'h0);
    check("mr_ireq",      16'(bus.imem_req), 16'h1);
    step();
    check("mr_still_fetch", 16'(bus.imem_req), 16'h1);
    check("mr_no_write", 16'(w_en_cnt - w_base), 16'h0);
    fetch(16'hA000);
    check("mr_restart_inc", 16'(bus.rf_pc_inc), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
